encoder_3r: RTL

//  Inverse of the ID-stage 3R decoder: encodes an internal 8-bit OP_* code plus register/immediate fields into a 32-bit LA32R 3R/2RI5/code-15 instruction word.

---
 rtl/encoder_3r_pkg.sv | 56 +++++
 rtl/encoder_3r_comb.sv | 66 ++++++
 rtl/encoder_3r.sv | 101 ++++++++++
 3 files changed

// File: rtl/encoder_3r_pkg.sv
// Shared opcode space for the 3R encoder: internal OP_* codes, LA32R func8 values
// and the fixed upper bits of a BREAK word.
package encoder_3r_pkg;

    localparam logic [7:0] OP_ADD     = 8'h01;
    localparam logic [7:0] OP_SUB     = 8'h02;
    localparam logic [7:0] OP_SLT     = 8'h03;
    localparam logic [7:0] OP_SLTU    = 8'h04;
    localparam logic [7:0] OP_NOR     = 8'h05;
    localparam logic [7:0] OP_AND     = 8'h06;
    localparam logic [7:0] OP_OR      = 8'h07;
    localparam logic [7:0] OP_XOR     = 8'h08;
    localparam logic [7:0] OP_SLL     = 8'h09;
    localparam logic [7:0] OP_SRL     = 8'h0A;
    localparam logic [7:0] OP_SRA     = 8'h0B;
    localparam logic [7:0] OP_MUL     = 8'h0C;
    localparam logic [7:0] OP_MULH    = 8'h0D;
    localparam logic [7:0] OP_MULHU   = 8'h0E;
    localparam logic [7:0] OP_DIV     = 8'h0F;
    localparam logic [7:0] OP_MOD     = 8'h10;
    localparam logic [7:0] OP_DIVU    = 8'h11;
    localparam logic [7:0] OP_MODU    = 8'h12;
    localparam logic [7:0] OP_BREAK   = 8'h13;
    localparam logic [7:0] OP_SYSCALL = 8'h14;
    localparam logic [7:0] OP_SLLI    = 8'h15;
    localparam logic [7:0] OP_SRLI    = 8'h16;
    localparam logic [7:0] OP_SRAI    = 8'h17;

    localparam logic [7:0] FUNC8_ADD     = 8'h20;
    localparam logic [7:0] FUNC8_SUB     = 8'h22;
    localparam logic [7:0] FUNC8_SLT     = 8'h24;
    localparam logic [7:0] FUNC8_SLTU    = 8'h25;
    localparam logic [7:0] FUNC8_NOR     = 8'h28;
    localparam logic [7:0] FUNC8_AND     = 8'h29;
    localparam logic [7:0] FUNC8_OR      = 8'h2A;
    localparam logic [7:0] FUNC8_XOR     = 8'h2B;
    localparam logic [7:0] FUNC8_SLL     = 8'h2E;
    localparam logic [7:0] FUNC8_SRL     = 8'h2F;
    localparam logic [7:0] FUNC8_SRA     = 8'h30;
    localparam logic [7:0] FUNC8_MUL     = 8'h38;
    localparam logic [7:0] FUNC8_MULH    = 8'h39;
    localparam logic [7:0] FUNC8_MULHU   = 8'h3A;
    localparam logic [7:0] FUNC8_DIV     = 8'h40;
    localparam logic [7:0] FUNC8_MOD     = 8'h41;
    localparam logic [7:0] FUNC8_DIVU    = 8'h42;
    localparam logic [7:0] FUNC8_MODU    = 8'h43;
    localparam logic [7:0] FUNC8_BREAK   = 8'h54;
    localparam logic [7:0] FUNC8_SYSCALL = 8'h56;
    localparam logic [7:0] FUNC8_SLLI    = 8'h81;
    localparam logic [7:0] FUNC8_SRLI    = 8'h89;
    localparam logic [7:0] FUNC8_SRAI    = 8'h91;

    // inst[31:15] of a BREAK word
    localparam logic [16:0] INST_BREAK_HI = 17'h00054;

endpackage

// File: rtl/encoder_3r_comb.sv
// Pure combinational OP_* + fields -> 32-bit LA32R word; unsupported ops yield
// a BREAK carrying the op code, with legal_o low.
module enc_3r_comb
    import encoder_3r_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rj_i,
    input  logic [4:0]  rk_i,
    input  logic [14:0] code_i,
    output logic [31:0] inst_o,
    output logic        legal_o
);

    logic [7:0] func8;
    logic       use_code;

    always_comb begin
        func8    = 8'h00;
        legal_o  = 1'b1;
        use_code = 1'b0;
        case (op_i)
            OP_ADD:     func8 = FUNC8_ADD;
            OP_SUB:     func8 = FUNC8_SUB;
            OP_SLT:     func8 = FUNC8_SLT;
            OP_SLTU:    func8 = FUNC8_SLTU;
            OP_NOR:     func8 = FUNC8_NOR;
            OP_AND:     func8 = FUNC8_AND;
            OP_OR:      func8 = FUNC8_OR;
            OP_XOR:     func8 = FUNC8_XOR;
            OP_SLL:     func8 = FUNC8_SLL;
            OP_SRL:     func8 = FUNC8_SRL;
            OP_SRA:     func8 = FUNC8_SRA;
            OP_MUL:     func8 = FUNC8_MUL;
            OP_MULH:    func8 = FUNC8_MULH;
            OP_MULHU:   func8 = FUNC8_MULHU;
            OP_DIV:     func8 = FUNC8_DIV;
            OP_MOD:     func8 = FUNC8_MOD;
            OP_DIVU:    func8 = FUNC8_DIVU;
            OP_MODU:    func8 = FUNC8_MODU;
            OP_SLLI:    func8 = FUNC8_SLLI;
            OP_SRLI:    func8 = FUNC8_SRLI;
            OP_SRAI:    func8 = FUNC8_SRAI;
            OP_BREAK: begin
                func8    = FUNC8_BREAK;
                use_code = 1'b1;
            end
            OP_SYSCALL: begin
                func8    = FUNC8_SYSCALL;
                use_code = 1'b1;
            end
            default:    legal_o = 1'b0;
        endcase
    end

    always_comb begin
        inst_o = 32'h0;
        if (!legal_o)
            inst_o = {INST_BREAK_HI, 7'b0, op_i};
        else if (use_code)
            inst_o = {9'b0, func8, code_i};
        else
            inst_o = {9'b0, func8, rk_i, rj_i, rd_i};
    end

endmodule

// File: rtl/encoder_3r.sv
// 3R/2RI5/code-15 instruction encoder feeding a DEPTH-entry valid/ready FIFO.
// Optional ENC_ILLEGAL_TRAP_EN: unsupported ops push a BREAK word instead of nothing.
module encoder_3r
    import encoder_3r_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rj,
    input  logic [4:0]  in_rk,
    input  logic [14:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        enc_err
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          enc_err_q, enc_err_d;

    logic [31:0]   enc_inst;
    logic          enc_legal;
    logic          accept, push, pop;

    enc_3r_comb u_comb (
        .op_i    (in_op),
        .rd_i    (in_rd),
        .rj_i    (in_rj),
        .rk_i    (in_rk),
        .code_i  (in_code),
        .inst_o  (enc_inst),
        .legal_o (enc_legal)
    );

    assign in_ready  = (count_q != CNT_FULL) && !flush;
    assign out_valid = (count_q != '0);
    assign out_inst  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign enc_err   = enc_err_q;

    assign accept = in_valid && in_ready;
`ifdef ENC_ILLEGAL_TRAP_EN
    assign push   = accept;
`else
    assign push   = accept && enc_legal;
`endif
    assign pop    = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        enc_err_d = accept && !enc_legal;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            enc_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            enc_err_q <= enc_err_d;
        end
    end

    // Storage is not reset; out_inst is masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= enc_inst;
    end

endmodule
